// File: rtl/servix_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// servix_rst_seq_pkg
// Shared constants for the servix reset sequencer. The reset-cause encodings
// are the values software reads back from o_cause, so the firmware headers
// and the RTL are generated from / checked against this one place.
// -----------------------------------------------------------------------------
package servix_rst_seq_pkg;

  // Cause of the most recent reset as reported on o_cause. 2'b11 is unused.
  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,  // PLL power-on reset from the clock generator
    CAUSE_BTN = 2'b01,  // debounced external reset button
    CAUSE_SW  = 2'b10   // software request from the core
  } cause_e;

  // Width of a counter that must hold values 0 .. max(a, b)-1.
  // Never returns 0 so that a 1-cycle configuration still gets a legal vector.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage : servix_rst_seq_pkg

// File: rtl/servix_debounce.sv
// -----------------------------------------------------------------------------
// servix_debounce
// Two-flop synchronizer followed by a stability-counter debouncer for a raw,
// asynchronous, active-high board button. Emits a single-cycle pulse when the
// debounced state goes 0 -> 1.
//
// Ports:
//   i_clk    in  1  clock
//   i_rst    in  1  synchronous active-high reset, clears all state
//   i_btn    in  1  raw asynchronous button input
//   o_event  out 1  one-cycle pulse on each debounced press
// -----------------------------------------------------------------------------
module servix_debounce #(
  parameter int debounce_cycles = 65536   // must be >= 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_event
);

  localparam int              DW   = $clog2(debounce_cycles);
  localparam logic [DW-1:0]   TERM = DW'(debounce_cycles - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_event;
  logic [DW-1:0] r_cnt;

  // NOTE: all state here is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking would collapse the
  // synchronizer into a single stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_event <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_event <= 1'b0;
      if (r_sync2 == r_deb) begin
        // Any agreement with the stable state restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == TERM) begin
        // Input has disagreed for debounce_cycles consecutive samples: accept it.
        r_deb   <= r_sync2;
        r_cnt   <= '0;
        r_event <= r_sync2;   // pulse only on the 0 -> 1 change
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_event = r_event;

endmodule : servix_debounce

// File: rtl/servix_rst_seq.sv
// -----------------------------------------------------------------------------
// servix_rst_seq
// Reset sequencer for the servix SoC. Merges PLL power-on reset, a debounced
// reset button and a software reset request, stretches the combined reset and
// releases the peripheral reset before the core reset. Records the cause of
// the most recent reset.
//
// Ports:
//   i_clk         in  1  system clock from the clock generator
//   i_rst         in  1  PLL-derived reset, synchronous active-high
//   i_btn         in  1  raw external reset button, asynchronous active-high
//   i_sw_rst      in  1  one-cycle software reset request from the core
//   o_rst_periph  out 1  active-high reset for memory and peripherals
//   o_rst_core    out 1  active-high reset for the serv core
//   o_cause       out 2  00 = PLL/POR, 01 = button, 10 = software
// -----------------------------------------------------------------------------
module servix_rst_seq
  import servix_rst_seq_pkg::*;
#(
  parameter int hold_cycles     = 256,    // >= 1
  parameter int stagger_cycles  = 16,     // >= 1
  parameter int debounce_cycles = 65536   // >= 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  input  logic       i_sw_rst,
  output logic       o_rst_periph,
  output logic       o_rst_core,
  output logic [1:0] o_cause
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,  // both resets asserted
    ST_STAGGER = 2'b01,  // peripherals released, core still held
    ST_RUN     = 2'b10   // everything released
  } state_e;

  localparam int            CW           = cnt_width(hold_cycles, stagger_cycles);
  localparam logic [CW-1:0] HOLD_TERM    = CW'(hold_cycles - 1);
  localparam logic [CW-1:0] STAGGER_TERM = CW'(stagger_cycles - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  cause_e        r_cause;
  cause_e        w_cause_nxt;
  logic          r_rst_periph;
  logic          r_rst_core;
  logic          w_btn_event;

  servix_debounce #(
    .debounce_cycles (debounce_cycles)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn),
    .o_event (w_btn_event)
  );

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;

    if (w_btn_event) begin
      // Button outranks a simultaneous software request.
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_cause_nxt = CAUSE_BTN;
    end else if (i_sw_rst) begin
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_cause_nxt = CAUSE_SW;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_TERM) begin
            w_state_nxt = ST_STAGGER;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_STAGGER: begin
          if (r_cnt == STAGGER_TERM) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          // Unreachable encoding: recover into a full reset.
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they switch on the same edge as the state and have no input-to-output path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_cause      <= CAUSE_POR;
      r_rst_periph <= 1'b1;
      r_rst_core   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cause      <= w_cause_nxt;
      r_rst_periph <= (w_state_nxt == ST_HOLD);
      r_rst_core   <= (w_state_nxt != ST_RUN);
    end
  end

  assign o_rst_periph = r_rst_periph;
  assign o_rst_core   = r_rst_core;
  assign o_cause      = r_cause;

endmodule : servix_rst_seq

// File: tb/tb_servix_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_servix_rst_seq
// Directed testbench for servix_rst_seq with hold=8, stagger=4, debounce=4.
// Outputs are compared as the packed vector {periph, core, cause[1:0]}.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_servix_rst_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_btn;
  logic       i_sw_rst;
  logic       o_rst_periph;
  logic       o_rst_core;
  logic [1:0] o_cause;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_BTN = 2'b01;
  localparam logic [1:0] C_SW  = 2'b10;

  servix_rst_seq #(
    .hold_cycles     (8),
    .stagger_cycles  (4),
    .debounce_cycles (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_btn        (i_btn),
    .i_sw_rst     (i_sw_rst),
    .o_rst_periph (o_rst_periph),
    .o_rst_core   (o_rst_core),
    .o_cause      (o_cause)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // 1. Power-on: outputs held during i_rst, then staggered release.
  task automatic test_reset();
    logic [3:0] exp;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = {1'b1, 1'b1, C_POR};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL por_hold cyc %0d: got %b want %b", i, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_rst = 1'b0;
    // e = 1 is the first edge that samples i_rst low.
    for (int e = 1; e <= 16; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_POR};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL por_release edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  // 2. Software reset from RUN.
  task automatic test_sw_from_run();
    logic [3:0] exp;
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    exp = {1'b1, 1'b1, C_SW};
    checks++;
    if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
      errors++;
      $display("FAIL sw_assert: got %b want %b", {o_rst_periph, o_rst_core, o_cause}, exp);
    end
    for (int e = 1; e <= 14; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL sw_release edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  // 3. Bouncing button is ignored, a stable press resets once, a held button
  //    lets the sequence finish, and a release produces nothing.
  task automatic test_button();
    logic [3:0] exp;
    for (int i = 0; i < 12; i++) begin
      i_btn = ((i / 2) % 2) == 0;
      step();
      exp = {1'b0, 1'b0, C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL btn_bounce cyc %0d: got %b want %b", i, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_btn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp = (e < 7) ? {1'b0, 1'b0, C_SW} : {1'b1, 1'b1, C_BTN};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL btn_latency edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    for (int e = 1; e <= 22; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_BTN};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL btn_held edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = {1'b0, 1'b0, C_BTN};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL btn_release cyc %0d: got %b want %b", i, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  // 4. Button event and software request sampled on the same edge.
  task automatic test_simultaneous();
    logic [3:0] exp;
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    i_btn    = 1'b1;
    // Button event is high after the 6th edge; software request lands on the 7th.
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {1'b1, 1'b1, C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL simul_pre edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    exp = {1'b1, 1'b1, C_BTN};
    checks++;
    if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
      errors++;
      $display("FAIL simul_cause: got %b want %b", {o_rst_periph, o_rst_core, o_cause}, exp);
    end
    for (int e = 1; e <= 12; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_BTN};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL simul_release edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = {1'b0, 1'b0, C_BTN};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL simul_idle cyc %0d: got %b want %b", i, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  // 5. Request during HOLD extends the hold; request during STAGGER re-asserts
  //    the peripheral reset on the next edge.
  task automatic test_extend_interrupt();
    logic [3:0] exp;
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      exp = {1'b1, 1'b1, C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL ext_first edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    // Count is now 5: second request restarts the hold.
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp = {(e < 8), 1'b1, C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL ext_restart edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    // Now in STAGGER.
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    exp = {1'b1, 1'b1, C_SW};
    checks++;
    if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
      errors++;
      $display("FAIL stagger_interrupt: got %b want %b", {o_rst_periph, o_rst_core, o_cause}, exp);
    end
    for (int e = 1; e <= 12; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL stagger_release edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  // 6. i_rst while the debounce counter is running; i_rst also overrides a
  //    concurrent software request.
  task automatic test_rst_mid_debounce();
    logic [3:0] exp;
    i_btn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      exp = {1'b0, 1'b0, C_SW};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL mid_deb_pre edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
    i_rst    = 1'b1;
    i_btn    = 1'b0;
    i_sw_rst = 1'b1;
    step();
    i_sw_rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp = {1'b1, 1'b1, C_POR};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL mid_deb_rst cyc %0d: got %b want %b", i, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
      step();
    end
    i_rst = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      exp = {(e < 8), (e < 12), C_POR};
      checks++;
      if ({o_rst_periph, o_rst_core, o_cause} !== exp) begin
        errors++;
        $display("FAIL mid_deb_release edge %0d: got %b want %b", e, {o_rst_periph, o_rst_core, o_cause}, exp);
      end
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_btn    = 1'b0;
    i_sw_rst = 1'b0;
    test_reset();
    test_sw_from_run();
    test_button();
    test_simultaneous();
    test_extend_interrupt();
    test_rst_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_servix_rst_seq
